// File: rtl/serial_arith_pkg.sv
// rtl/serial_arith_pkg.sv - shared types, constants and bit-level helpers for serial arithmetic
//
// Purpose : FSM state encoding, default operand width and the full-adder
//           primitives (xor3, majority) shared by the bit-slice cell and
//           the serial adder control.
// Ports   : none (package).
package serial_arith_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 8;

  function automatic logic xor3(input logic x, input logic y, input logic z);
    return x ^ y ^ z;
  endfunction

  function automatic logic majority(input logic x, input logic y, input logic z);
    return (x & y) | (x & z) | (y & z);
  endfunction

endpackage

// File: rtl/fa_cell.sv
// rtl/fa_cell.sv - combinational one-bit full adder slice
//
// Purpose : single full-adder bit slice, shaped like the existing
//           subtractor cells so serial datapaths share one structure.
// Ports   : a, b, c - operand bits and carry-in
//           s       - sum bit
//           co      - carry-out bit
module fa_cell
  import serial_arith_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic c,
  output logic s,
  output logic co
);

  assign s  = xor3(a, b, c);
  assign co = majority(a, b, c);

endmodule

// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial ripple adder over one full-adder slice
//
// Purpose : latches a, b, c on an accepted start, resolves one bit per
//           clock LSB first, then presents {cout, sum} = a + b + c with a
//           one-cycle done pulse. Initiation interval is WIDTH+1 cycles.
// Config  : SERIAL_ADDER_SUB_EN adds input 'sub'; when captured high the
//           result is a - b - c and cout reports borrow.
// Ports   : clk   - rising-edge clock
//           rst   - asynchronous active-high reset
//           start - request, sampled in IDLE and DONE only
//           a, b  - WIDTH-bit operands, captured on accepted start
//           c     - carry-in, captured on accepted start
//           sub   - (SERIAL_ADDER_SUB_EN only) subtract select
//           busy  - high while bits are being computed
//           done  - one-cycle result-valid pulse
//           sum   - WIDTH-bit result, held until the next completion
//           cout  - carry-out (borrow in subtract mode), held with sum
module serial_adder
  import serial_arith_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t           r_state;
  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic [WIDTH-1:0] r_sum_sh;
  logic             r_carry;
  logic [CW-1:0]    r_cnt;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;

  logic             w_sub_in;   // subtract request at the port
  logic             w_sub;      // subtract mode of the operation in flight
  logic             w_b_bit;
  logic             w_s;
  logic             w_co;
  logic [WIDTH-1:0] w_sum_next;
  logic             w_last;

`ifdef SERIAL_ADDER_SUB_EN
  logic r_sub;

  assign w_sub_in = sub;
  assign w_sub    = r_sub;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sub <= 1'b0;
    end else if ((r_state != RUN) && start) begin
      r_sub <= sub;
    end
  end
`else
  assign w_sub_in = 1'b0;
  assign w_sub    = 1'b0;
`endif

  // Subtraction is a + ~b + ~c: invert the addend bit and the initial carry.
  assign w_b_bit = r_b_sh[0] ^ w_sub;

  fa_cell u_fa (
    .a  (r_a_sh[0]),
    .b  (w_b_bit),
    .c  (r_carry),
    .s  (w_s),
    .co (w_co)
  );

  assign w_sum_next = {w_s, r_sum_sh[WIDTH-1:1]};
  assign w_last     = (r_cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_a_sh   <= '0;
      r_b_sh   <= '0;
      r_sum_sh <= '0;
      r_carry  <= 1'b0;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_sum    <= '0;
      r_cout   <= 1'b0;
    end else begin
      case (r_state)
        // DONE accepts a start exactly like IDLE so operations can abut.
        IDLE, DONE: begin
          r_done <= 1'b0;
          if (start) begin
            r_a_sh   <= a;
            r_b_sh   <= b;
            r_carry  <= c ^ w_sub_in;
            r_sum_sh <= '0;
            r_cnt    <= '0;
            r_busy   <= 1'b1;
            r_state  <= RUN;
          end else begin
            r_state  <= IDLE;
          end
        end
        RUN: begin
          r_a_sh   <= r_a_sh >> 1;
          r_b_sh   <= r_b_sh >> 1;
          r_carry  <= w_co;
          r_sum_sh <= w_sum_next;
          r_cnt    <= r_cnt + CW'(1);
          if (w_last) begin
            r_sum   <= w_sum_next;
            r_cout  <= w_co ^ w_sub;  // borrow is the inverted final carry
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= DONE;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign sum  = r_sum;
  assign cout = r_cout;

endmodule
